// File: rtl/mdu_div_unit_pkg.sv
// Shared encodings for the M-extension iterative divider: op codes, FSM states, default width.
package mdu_div_unit_pkg;
  localparam int MDU_DATA_WIDTH = 32;

  localparam logic [1:0] MDU_DIV  = 2'd0;
  localparam logic [1:0] MDU_DIVU = 2'd1;
  localparam logic [1:0] MDU_REM  = 2'd2;
  localparam logic [1:0] MDU_REMU = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;
endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module mdu_div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_rem,
  input  logic [DATA_WIDTH-1:0] i_quo,
  input  logic [DATA_WIDTH-1:0] i_dvs,
  output logic [DATA_WIDTH-1:0] o_rem,
  output logic [DATA_WIDTH-1:0] o_quo
);
  logic [DATA_WIDTH:0] w_rem_sh;
  logic [DATA_WIDTH:0] w_trial;
  logic                w_neg;

  // Remainder stays below the divisor, so the top trial bit alone marks a borrow.
  assign w_rem_sh = {i_rem, i_quo[DATA_WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, i_dvs};
  assign w_neg    = w_trial[DATA_WIDTH];

  assign o_rem = w_neg ? w_rem_sh[DATA_WIDTH-1:0] : w_trial[DATA_WIDTH-1:0];
  assign o_quo = {i_quo[DATA_WIDTH-2:0], ~w_neg};
endmodule

// File: rtl/mdu_div_unit.sv
// Iterative DIV/DIVU/REM/REMU unit: one restoring step per cycle, then sign fix-up.
// MDU_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow complete straight from IDLE.
module mdu_div_unit
  import mdu_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = MDU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_e            r_state, w_nxt;
  logic [CW-1:0]         r_cnt;
  logic [1:0]            r_op;
  logic                  r_sa, r_sb, r_div0, r_ovf;
  logic [DATA_WIDTH-1:0] r_rem, r_quo, r_dvs, r_result;

  logic                  w_sa, w_sb, w_div0, w_ovf, w_last;
  logic [DATA_WIDTH-1:0] w_abs_a, w_abs_b, w_step_rem, w_step_quo;
  logic [DATA_WIDTH-1:0] w_q_fix, w_r_fix, w_fix_res;

  // DIV and REM are the even op codes.
  assign w_sa    = ~op_i[0] & rs1_i[DATA_WIDTH-1];
  assign w_sb    = ~op_i[0] & rs2_i[DATA_WIDTH-1];
  assign w_abs_a = w_sa ? -rs1_i : rs1_i;
  assign w_abs_b = w_sb ? -rs2_i : rs2_i;
  assign w_div0  = (rs2_i == '0);
  assign w_ovf   = ~op_i[0] & (rs1_i == SMIN) & (rs2_i == '1);
  assign w_last  = (r_cnt == CW'(DATA_WIDTH-1));

`ifdef MDU_DIV_EARLY_OUT_EN
  logic                  w_special;
  logic [DATA_WIDTH-1:0] w_spec_res;
  assign w_special  = w_div0 | w_ovf;
  assign w_spec_res = w_div0 ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : SMIN);
`endif

  mdu_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  // With a zero divisor the datapath leaves |dividend| in r_rem, so the
  // sign-restored remainder is already the dividend; only the quotient needs overriding.
  assign w_q_fix   = r_div0 ? '1 :
                     r_ovf  ? SMIN :
                     ((r_op == MDU_DIV) && (r_sa ^ r_sb)) ? -r_quo : r_quo;
  assign w_r_fix   = r_ovf ? '0 :
                     ((r_op == MDU_REM) && r_sa) ? -r_rem : r_rem;
  assign w_fix_res = r_op[1] ? w_r_fix : w_q_fix;

  always_comb begin
    w_nxt  = r_state;
    busy_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy_o = start_i;
        if (start_i) begin
`ifdef MDU_DIV_EARLY_OUT_EN
          w_nxt = w_special ? ST_DONE : ST_CALC;
`else
          w_nxt = ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        busy_o = 1'b1;
        if (w_last) w_nxt = ST_FIX;
      end
      ST_FIX: begin
        busy_o = 1'b1;
        w_nxt  = ST_DONE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  assign done_o   = (r_state == ST_DONE);
  assign result_o = r_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_op     <= MDU_DIV;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        ST_IDLE: if (start_i) begin
          r_op   <= op_i;
          r_sa   <= w_sa;
          r_sb   <= w_sb;
          r_div0 <= w_div0;
          r_ovf  <= w_ovf;
          r_rem  <= '0;
          r_quo  <= w_abs_a;
          r_dvs  <= w_abs_b;
          r_cnt  <= '0;
`ifdef MDU_DIV_EARLY_OUT_EN
          if (w_special) r_result <= w_spec_res;
`endif
        end
        ST_CALC: begin
          r_rem <= w_step_rem;
          r_quo <= w_step_quo;
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
        ST_FIX:  r_result <= w_fix_res;
        default: ;
      endcase
    end
  end
endmodule
